conware_gen_sequencer: RTL

Top-level sequencer for the Conway's Game of Life pipeline. It takes one binary board from the AXI-Stream-to-buffer converter and holds it in a board register. It then iterates that board through the single-generation compute engine a programmed number of times and hands the final board to the output writer. All three neighbours use a valid/ready handshake; the sequencer owns the only copy of the board between generations.

---
 rtl/conware_gen_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/conware_gen_sequencer.sv
// conware_gen_sequencer: owns the Game of Life board between generations,
// loads it, iterates it through the compute engine, then writes it out.
//
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   start, abort        launch a run (IDLE only) / return to IDLE at once
//   num_gens            generation count, latched on the accepted start
//   load_ready/valid/data   board in from the stream-to-buffer converter
//   calc_valid/ready/data   board out to the single-generation engine
//   res_valid/data          next-generation board back from the engine
//   wr_valid/ready/data     final board out to the output writer
//   busy, done          not-IDLE flag / one-cycle completion pulse
//   gen_count           generations completed in the current or last run
module conware_gen_sequencer #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int CWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CWIDTH-1:0]       num_gens,
  output logic                    load_ready,
  input  logic                    load_valid,
  input  logic [WIDTH*HEIGHT-1:0] load_data,
  output logic                    calc_valid,
  output logic [WIDTH*HEIGHT-1:0] calc_data,
  input  logic                    calc_ready,
  input  logic                    res_valid,
  input  logic [WIDTH*HEIGHT-1:0] res_data,
  output logic                    wr_valid,
  output logic [WIDTH*HEIGHT-1:0] wr_data,
  input  logic                    wr_ready,
  output logic                    busy,
  output logic                    done,
  output logic [CWIDTH-1:0]       gen_count
);

  localparam int N = WIDTH * HEIGHT;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CALC     = 3'd2,
    WAIT_RES = 3'd3,
    WRITE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state;
  state_t state_n;

  logic [N-1:0]      board;
  logic [N-1:0]      board_n;
  logic [CWIDTH-1:0] gens_l;
  logic [CWIDTH-1:0] gens_l_n;
  logic [CWIDTH-1:0] gen_cnt;
  logic [CWIDTH-1:0] gen_cnt_n;
  logic [CWIDTH-1:0] gen_inc;

  // Cannot wrap: the run stops once the count reaches gens_l.
  assign gen_inc = gen_cnt + CWIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      board   <= '0;
      gens_l  <= '0;
      gen_cnt <= '0;
    end else begin
      state   <= state_n;
      board   <= board_n;
      gens_l  <= gens_l_n;
      gen_cnt <= gen_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    board_n   = board;
    gens_l_n  = gens_l;
    gen_cnt_n = gen_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          gens_l_n  = num_gens;
          gen_cnt_n = '0;
          state_n   = LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          board_n = load_data;
          state_n = (gens_l == '0) ? WRITE : CALC;
        end
      end
      CALC: begin
        if (calc_ready) state_n = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid) begin
          board_n   = res_data;
          gen_cnt_n = gen_inc;
          state_n   = (gen_inc == gens_l) ? WRITE : CALC;
        end
      end
      WRITE: begin
        if (wr_ready) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Abort wins over every transition and freezes the datapath,
    // so the partial board and count stay visible afterwards.
    if (abort) begin
      state_n   = IDLE;
      board_n   = board;
      gens_l_n  = gens_l;
      gen_cnt_n = gen_cnt;
    end
  end

  // Handshake and status outputs come straight from the state register.
  assign load_ready = (state == LOAD);
  assign calc_valid = (state == CALC);
  assign wr_valid   = (state == WRITE);
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

  assign calc_data = board;
  assign wr_data   = board;
  assign gen_count = gen_cnt;

endmodule
